training_sample_sequencer: RTL and testbench

//   Upstream feeder for the perceptron trainer. Replays the 4-row truth table of a
//   2-input logic function for EPOCHS passes, one sample per valid/ready beat.

---
 rtl/training_sample_sequencer.sv | 104 ++++++++++
 tb/tb_training_sample_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/training_sample_sequencer.sv
// Replays a 2-input truth table as fixed-point valid/ready beats for EPOCHS passes.
// Ports: clk_i, reset_i, start_i, abort_i, ready_i -> valid_o, x1_o, x2_o, target_o, sample_o, epoch_o, last_o, busy_o, done_o.
module training_sample_sequencer #(
  parameter int          EPOCHS      = 10,
  parameter logic [3:0]  TRUTH_TABLE = 4'b1000,
  parameter int          SIGN        = 1,
  parameter int          Q_M         = 15,
  parameter int          Q_N         = 16,
  localparam int         W           = SIGN + Q_M + Q_N,
  localparam int         EW          = $clog2(EPOCHS + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [W-1:0]  x1_o,
  output logic [W-1:0]  x2_o,
  output logic [W-1:0]  target_o,
  output logic [1:0]    sample_o,
  output logic [EW-1:0] epoch_o,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  localparam logic [W-1:0]  ONE     = W'(1) << Q_N;
  localparam logic [EW-1:0] LAST_EP = EW'(EPOCHS - 1);

  state_t        state, state_n;
  logic [1:0]    sample, sample_n;
  logic [EW-1:0] epoch, epoch_n;
  logic          issue;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      sample <= '0;
      epoch  <= '0;
    end else begin
      state  <= state_n;
      sample <= sample_n;
      epoch  <= epoch_n;
    end
  end

  // The final transfer bumps epoch to EPOCHS, so DONE shows it directly.
  always_comb begin
    state_n  = state;
    sample_n = sample;
    epoch_n  = epoch;
    unique case (state)
      ISSUE: begin
        if (abort_i) begin
          state_n  = IDLE;
          sample_n = '0;
          epoch_n  = '0;
        end else if (ready_i) begin
          if (sample == 2'd3) begin
            sample_n = '0;
            epoch_n  = epoch + 1'b1;
            if (epoch == LAST_EP) state_n = DONE;
          end else begin
            sample_n = sample + 2'd1;
          end
        end
      end
      default: begin
        if (abort_i) begin
          state_n  = IDLE;
          sample_n = '0;
          epoch_n  = '0;
        end else if (start_i) begin
          state_n  = ISSUE;
          sample_n = '0;
          epoch_n  = '0;
        end
      end
    endcase
  end

  assign issue = (state == ISSUE);

  // Data is gated by ISSUE so idle/done words are all zero.
  always_comb begin
    valid_o  = issue;
    busy_o   = issue;
    done_o   = (state == DONE);
    sample_o = issue ? sample : 2'd0;
    epoch_o  = epoch;
    last_o   = issue && (sample == 2'd3);
    x1_o     = (issue && sample[1]) ? ONE : '0;
    x2_o     = (issue && sample[0]) ? ONE : '0;
    target_o = (issue && TRUTH_TABLE[sample]) ? ONE : '0;
  end

endmodule

// File: tb/tb_training_sample_sequencer.sv
// Bench: AND/10-epoch and XOR/2-epoch sequencers vs a beat-count model.
// Random ready/start stimulus, aborts, async reset.
module tb_training_sample_sequencer;

  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;

  logic start_a = 0, abort_a = 0, ready_a = 0;
  logic start_x = 0, abort_x = 0, ready_x = 0;

  logic        valid_a, last_a, busy_a, done_a;
  logic [31:0] x1_a, x2_a, tgt_a;
  logic [1:0]  sample_a;
  logic [3:0]  epoch_a;

  logic        valid_x, last_x, busy_x, done_x;
  logic [31:0] x1_x, x2_x, tgt_x;
  logic [1:0]  sample_x;
  logic [1:0]  epoch_x;

  always #5 clk_i = ~clk_i;

  training_sample_sequencer dut_a (
    .clk_i(clk_i), .reset_i(reset_i),
    .start_i(start_a), .abort_i(abort_a), .ready_i(ready_a),
    .valid_o(valid_a), .x1_o(x1_a), .x2_o(x2_a), .target_o(tgt_a),
    .sample_o(sample_a), .epoch_o(epoch_a), .last_o(last_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  training_sample_sequencer #(
    .EPOCHS(2), .TRUTH_TABLE(4'b0110)
  ) dut_x (
    .clk_i(clk_i), .reset_i(reset_i),
    .start_i(start_x), .abort_i(abort_x), .ready_i(ready_x),
    .valid_o(valid_x), .x1_o(x1_x), .x2_o(x2_x), .target_o(tgt_x),
    .sample_o(sample_x), .epoch_o(epoch_x), .last_o(last_x),
    .busy_o(busy_x), .done_o(done_x)
  );

  int checks = 0;
  int errors = 0;

  int         eps [2] = '{10, 2};
  logic [3:0] tts [2] = '{4'b1000, 4'b0110};
  bit         mbusy [2];
  bit         mdone [2];
  int         mk [2];
  int         xfer [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(int i);
    mbusy[i] = 0;
    mdone[i] = 0;
    mk[i]    = 0;
  endtask

  task automatic check_outs(int i);
    string nm;
    int s, e;
    logic [31:0] ov, ox1, ox2, otg, osm, oep, ol, ob, od;
    nm = (i == 0) ? "and" : "xor";
    s = mk[i] % 4;
    e = mbusy[i] ? mk[i] / 4 : (mdone[i] ? eps[i] : 0);
    if (i == 0) begin
      ov = 32'(valid_a); ox1 = x1_a; ox2 = x2_a; otg = tgt_a;
      osm = 32'(sample_a); oep = 32'(epoch_a); ol = 32'(last_a);
      ob = 32'(busy_a); od = 32'(done_a);
    end else begin
      ov = 32'(valid_x); ox1 = x1_x; ox2 = x2_x; otg = tgt_x;
      osm = 32'(sample_x); oep = 32'(epoch_x); ol = 32'(last_x);
      ob = 32'(busy_x); od = 32'(done_x);
    end
    check({nm, ".valid"}, ov, 32'(mbusy[i]));
    check({nm, ".busy"}, ob, 32'(mbusy[i]));
    check({nm, ".done"}, od, 32'(mdone[i]));
    check({nm, ".sample"}, osm, mbusy[i] ? s : 0);
    check({nm, ".epoch"}, oep, e);
    check({nm, ".last"}, ol, 32'(mbusy[i] && s == 3));
    check({nm, ".x1"}, ox1, (mbusy[i] && s >= 2) ? ONE : 0);
    check({nm, ".x2"}, ox2, (mbusy[i] && s % 2 == 1) ? ONE : 0);
    check({nm, ".target"}, otg, (mbusy[i] && tts[i][s]) ? ONE : 0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(int i, logic st, logic ab, logic rd);
    check_outs(i);
    if (i == 0) begin
      start_a = st; abort_a = ab; ready_a = rd;
      start_x = 0;  abort_x = 0;  ready_x = 0;
      if (valid_a && rd && !ab) xfer[0]++;
    end else begin
      start_x = st; abort_x = ab; ready_x = rd;
      start_a = 0;  abort_a = 0;  ready_a = 0;
      if (valid_x && rd && !ab) xfer[1]++;
    end
    @(posedge clk_i);
    if (ab) begin
      model_clear(i);
    end else if (!mbusy[i] && st) begin
      model_clear(i);
      mbusy[i] = 1;
    end else if (mbusy[i] && rd) begin
      mk[i]++;
      if (mk[i] == 4 * eps[i]) begin
        mbusy[i] = 0;
        mdone[i] = 1;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic run_to_done(int i, bit rand_rdy, bit rand_st, int budget);
    int n;
    logic rd, st;
    n = 0;
    while (!mdone[i] && n < budget) begin
      rd = rand_rdy ? logic'($urandom_range(0, 1)) : 1'b1;
      st = rand_st ? logic'($urandom_range(0, 3) == 0) : 1'b0;
      step(i, st, 1'b0, rd);
      n++;
    end
    check("run.budget", 32'(n < budget), 1);
    check("run.done_o", 32'(i == 0 ? done_a : done_x), 1);
  endtask

  initial begin
    int cnt;
    model_clear(0);
    model_clear(1);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    check_outs(0);
    check_outs(1);

    // AND, ready held high: 40 back-to-back beats
    step(0, 1, 0, 1);
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (valid_a) cnt++;
      if (j == 3) begin
        check("and.beat3.x1", x1_a, ONE);
        check("and.beat3.last", 32'(last_a), 1);
      end
      step(0, 0, 0, 1);
    end
    check("and.valid_cycles", cnt, 40);
    check("and.end.valid", 32'(valid_a), 0);
    check("and.end.done", 32'(done_a), 1);

    // start in DONE, random backpressure
    xfer[0] = 0;
    step(0, 1, 0, 1);
    run_to_done(0, 1, 0, 1000);
    check("and.bp.beats", xfer[0], 40);

    // start pulses during ISSUE are ignored
    xfer[0] = 0;
    step(0, 1, 0, 0);
    run_to_done(0, 1, 1, 1000);
    check("and.ign.beats", xfer[0], 40);

    // XOR, 2 epochs
    xfer[1] = 0;
    step(1, 1, 0, 1);
    run_to_done(1, 1, 0, 200);
    check("xor.beats", xfer[1], 8);
    check("xor.epoch", 32'(epoch_x), 2);

    // abort at beat 6 with ready high
    step(0, 1, 0, 1);
    while (mk[0] != 6) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    check("abort.busy", 32'(busy_a), 0);
    check("abort.epoch", 32'(epoch_a), 0);
    xfer[0] = 0;
    step(0, 1, 0, 1);
    check("restart.sample", 32'(sample_a), 0);
    run_to_done(0, 0, 0, 100);
    check("restart.beats", xfer[0], 40);

    // start+abort together in DONE: abort wins
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    check("sa.done", 32'(done_a), 0);
    check("sa.valid", 32'(valid_a), 0);

    // asynchronous reset mid-run
    step(0, 1, 0, 1);
    repeat (5) step(0, 0, 0, 1);
    #2 reset_i = 1'b1;
    #1;
    model_clear(0);
    model_clear(1);
    check_outs(0);
    check_outs(1);
    @(negedge clk_i);
    reset_i = 1'b0;
    step(0, 0, 0, 1);
    check_outs(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
